// File: rtl/fp_loader_pkg.sv
// Shared types and default timing for the front-panel image loader.
// Words are 12-bit PDP-8 quantities; the phase timer counts in a fixed 16-bit domain.
package fp_loader_pkg;

   localparam int unsigned WordWidth  = 12;
   localparam int unsigned TimerWidth = 16;
   localparam int unsigned CountWidth = 13;

   typedef logic [WordWidth-1:0]  word_t;
   typedef logic [TimerWidth-1:0] count_t;
   typedef logic [CountWidth-1:0] words_t;

   localparam int unsigned DefSetupCycles = 10;
   localparam int unsigned DefHoldCycles  = 10;
   localparam int unsigned DefGapCycles   = 30;
   localparam int unsigned DefRunTimeout  = 1024;
   localparam word_t       DefStartPc     = 12'o0200;

   localparam words_t      WordsMax       = 13'd4096;
   localparam int unsigned MaxTimerLoad   = 2 ** TimerWidth;

   typedef enum logic [3:0] {
      StIdle,
      StWaitWord,
      StASetup,
      StAPress,
      StAGap,
      StDSetup,
      StDPress,
      StDGap,
      StPSetup,
      StPPress,
      StPGap,
      StRunWait,
      StRunning,
      StHalted
   } loader_state_t;

   function automatic logic is_busy(input loader_state_t s);
      return !((s == StIdle) || (s == StHalted));
   endfunction

endpackage

// File: rtl/fp_phase_timer.sv
// Down-counter shared by every timed phase of the loader.
// A load of N-1 makes done rise on the Nth cycle of the phase.
module fp_phase_timer
   import fp_loader_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   load,
   input  count_t load_value,
   output logic   done
);

   count_t count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - count_t'(1);
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/fp_image_loader.sv
// Front-panel sequencer: deposits an (address, data) word stream through the
// load-PC / deposit buttons, then loads the start PC, runs, and watches for halt.
module fp_image_loader
   import fp_loader_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES = DefSetupCycles,
   parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
   parameter int unsigned GAP_CYCLES   = DefGapCycles,
   parameter word_t       START_PC     = DefStartPc,
   parameter int unsigned RUN_TIMEOUT  = DefRunTimeout
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic [11:0] word_addr,
   input  logic [11:0] word_data,
   input  logic        word_last,
   input  logic        run_led,
   output logic [12:0] sw,
   output logic        btnl,
   output logic        btnd,
   output logic        busy,
   output logic        halted,
   output logic        error,
   output logic [12:0] words_loaded
);

   if (SETUP_CYCLES == 0 || HOLD_CYCLES == 0 || GAP_CYCLES == 0 || RUN_TIMEOUT == 0 ||
       SETUP_CYCLES > MaxTimerLoad || HOLD_CYCLES > MaxTimerLoad ||
       GAP_CYCLES > MaxTimerLoad || RUN_TIMEOUT > MaxTimerLoad) begin : gen_bad_params
      $error("fp_image_loader: timing parameters must be in 1..2**TimerWidth");
   end

   loader_state_t state_q, state_d;
   logic [12:0]   sw_q, sw_d;
   word_t         data_q, data_d;
   logic          last_q, last_d;
   words_t        words_q, words_d;
   logic          error_q, error_d;
   logic          halted_q, halted_d;
   logic          btnl_q, btnd_q, busy_q, ready_q;
   logic          run_led_q;

   logic          timer_load;
   count_t        timer_value;
   logic          timer_done;

   // Duration of the phase being entered; the counter is loaded with N-1.
   function automatic count_t phase_len(input loader_state_t s);
      count_t len;
      case (s)
         StASetup, StDSetup, StPSetup: len = count_t'(SETUP_CYCLES - 1);
         StAPress, StDPress, StPPress: len = count_t'(HOLD_CYCLES - 1);
         StAGap, StDGap, StPGap:       len = count_t'(GAP_CYCLES - 1);
         StRunWait:                    len = count_t'(RUN_TIMEOUT - 1);
         default:                      len = '0;
      endcase
      return len;
   endfunction

   always_comb begin
      state_d  = state_q;
      sw_d     = sw_q;
      data_d   = data_q;
      last_d   = last_q;
      words_d  = words_q;
      error_d  = error_q;
      halted_d = 1'b0;

      case (state_q)
         StIdle, StHalted: begin
            if (start) begin
               state_d = StWaitWord;
               error_d = 1'b0;
               words_d = '0;
            end
         end
         StWaitWord: begin
            if (word_valid) begin
               state_d    = StASetup;
               sw_d[11:0] = word_addr;
               data_d     = word_data;
               last_d     = word_last;
            end
         end
         StASetup: if (timer_done) state_d = StAPress;
         StAPress: if (timer_done) state_d = StAGap;
         StAGap: begin
            if (timer_done) begin
               state_d    = StDSetup;
               sw_d[11:0] = data_q;
            end
         end
         StDSetup: if (timer_done) state_d = StDPress;
         StDPress: if (timer_done) state_d = StDGap;
         StDGap: begin
            if (timer_done) begin
               if (words_q != WordsMax) begin
                  words_d = words_q + 13'd1;
               end
               if (last_q) begin
                  state_d    = StPSetup;
                  sw_d[11:0] = START_PC;
               end else begin
                  state_d = StWaitWord;
               end
            end
         end
         StPSetup: if (timer_done) state_d = StPPress;
         StPPress: if (timer_done) state_d = StPGap;
         StPGap: begin
            if (timer_done) begin
               state_d  = StRunWait;
               sw_d[12] = 1'b1;
            end
         end
         StRunWait: begin
            if (run_led) begin
               state_d = StRunning;
            end else if (timer_done) begin
               state_d  = StHalted;
               error_d  = 1'b1;
               sw_d[12] = 1'b0;
            end
         end
         StRunning: begin
            // Falling edge against the previous-cycle sample of the LED.
            if (run_led_q && !run_led) begin
               state_d  = StHalted;
               halted_d = 1'b1;
               sw_d[12] = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign timer_load  = (state_d != state_q);
   assign timer_value = phase_len(state_d);

   fp_phase_timer u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   // Button and handshake outputs are decoded from the next state so they
   // change on the same edge as the state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         sw_q      <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         words_q   <= '0;
         error_q   <= 1'b0;
         halted_q  <= 1'b0;
         btnl_q    <= 1'b0;
         btnd_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         run_led_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sw_q      <= sw_d;
         data_q    <= data_d;
         last_q    <= last_d;
         words_q   <= words_d;
         error_q   <= error_d;
         halted_q  <= halted_d;
         btnl_q    <= (state_d == StAPress) || (state_d == StPPress);
         btnd_q    <= (state_d == StDPress);
         busy_q    <= is_busy(state_d);
         ready_q   <= (state_d == StWaitWord);
         run_led_q <= run_led;
      end
   end

   assign sw           = sw_q;
   assign btnl         = btnl_q;
   assign btnd         = btnd_q;
   assign busy         = busy_q;
   assign halted       = halted_q;
   assign error        = error_q;
   assign words_loaded = words_q;
   assign word_ready   = ready_q;

endmodule

// File: tb/tb_fp_image_loader.sv
// Directed bench for fp_image_loader: table-driven timing of a one-word load,
// then stream, timeout, mid-sequence reset and start-while-busy sequences.
module tb_fp_image_loader;

   logic        clock = 1'b0;
   logic        reset, start, word_valid, word_last, run_led;
   logic [11:0] word_addr, word_data;
   logic        word_ready, btnl, btnd, busy, halted, error;
   logic [12:0] sw, words_loaded;

   fp_image_loader dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_addr    (word_addr),
      .word_data    (word_data),
      .word_last    (word_last),
      .run_led      (run_led),
      .sw           (sw),
      .btnl         (btnl),
      .btnd         (btnd),
      .busy         (busy),
      .halted       (halted),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Invariant monitor and button-press scoreboard.
   int          mon_viol = 0;
   int          halted_cnt = 0;
   logic        btnl_prev = 1'b0, btnd_prev = 1'b0;
   logic [11:0] sw_prev = '0;
   logic [11:0] addr_log[$];
   logic [11:0] data_log[$];

   always @(negedge clock) begin
      mon_viol <= mon_viol + int'(btnl && btnd)
                           + int'((btnl || btnd) && (sw[11:0] != sw_prev))
                           + int'(word_ready && (btnl || btnd || !busy));
      if (halted) halted_cnt <= halted_cnt + 1;
      if (btnl && !btnl_prev) addr_log.push_back(sw[11:0]);
      if (btnd && !btnd_prev) data_log.push_back(sw[11:0]);
      btnl_prev <= btnl;
      btnd_prev <= btnd;
      sw_prev   <= sw[11:0];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Returns just after the accepting edge.
   task automatic send_word(input logic [11:0] a, input logic [11:0] d, input logic l);
      int n = 0;
      word_addr  = a;
      word_data  = d;
      word_last  = l;
      word_valid = 1'b1;
      while (word_ready !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      check("accept_wait", 64'(n < 2000), 64'd1);
      tick(1);
      word_valid = 1'b0;
   endtask

   function automatic logic [29:0] obs();
      return {sw, btnl, btnd, word_ready, busy, words_loaded};
   endfunction

   typedef struct {
      int          off;
      logic [12:0] sw;
      logic        btnl;
      logic        btnd;
      logic        ready;
      logic        busy;
      logic [12:0] words;
   } vec_t;

   function automatic vec_t mk(input int off, input logic [12:0] s, input logic l,
                               input logic d, input logic r, input logic b,
                               input logic [12:0] w);
      vec_t v;
      v.off = off; v.sw = s; v.btnl = l; v.btnd = d; v.ready = r; v.busy = b; v.words = w;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      int base, t_run, n, ab, db;
      logic [11:0] exp_addr[4];
      logic [11:0] exp_data[3];

      // Offsets count edges after the accepting edge; sampled 1 time unit later.
      vecs.push_back(mk(0,   13'h0080, 0, 0, 0, 1, 0));
      vecs.push_back(mk(9,   13'h0080, 0, 0, 0, 1, 0));
      vecs.push_back(mk(10,  13'h0080, 1, 0, 0, 1, 0));
      vecs.push_back(mk(19,  13'h0080, 1, 0, 0, 1, 0));
      vecs.push_back(mk(20,  13'h0080, 0, 0, 0, 1, 0));
      vecs.push_back(mk(49,  13'h0080, 0, 0, 0, 1, 0));
      vecs.push_back(mk(50,  13'h0F02, 0, 0, 0, 1, 0));
      vecs.push_back(mk(59,  13'h0F02, 0, 0, 0, 1, 0));
      vecs.push_back(mk(60,  13'h0F02, 0, 1, 0, 1, 0));
      vecs.push_back(mk(69,  13'h0F02, 0, 1, 0, 1, 0));
      vecs.push_back(mk(70,  13'h0F02, 0, 0, 0, 1, 0));
      vecs.push_back(mk(99,  13'h0F02, 0, 0, 0, 1, 0));
      vecs.push_back(mk(100, 13'h0080, 0, 0, 0, 1, 1));
      vecs.push_back(mk(110, 13'h0080, 1, 0, 0, 1, 1));
      vecs.push_back(mk(119, 13'h0080, 1, 0, 0, 1, 1));
      vecs.push_back(mk(120, 13'h0080, 0, 0, 0, 1, 1));
      vecs.push_back(mk(149, 13'h0080, 0, 0, 0, 1, 1));
      vecs.push_back(mk(150, 13'h1080, 0, 0, 0, 1, 1));

      reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_last = 1'b0; run_led = 1'b0;
      word_addr = '0; word_data = '0;
      tick(3);
      check("reset_state", {obs(), error, halted}, '0);
      reset = 1'b0;

      // Valid in IDLE is ignored.
      word_valid = 1'b1;
      tick(3);
      check("idle_ignores_valid", {word_ready, busy, btnl, btnd}, 4'b0000);
      word_valid = 1'b0;

      pulse_start();
      check("start_enter", {word_ready, busy, words_loaded}, {1'b1, 1'b1, 13'd0});

      // One-word image with last set.
      send_word(12'o0200, 12'o7402, 1'b1);
      base = cyc;
      foreach (vecs[i]) begin
         tick(vecs[i].off - (cyc - base));
         check($sformatf("word1_off%0d", vecs[i].off), obs(),
               {vecs[i].sw, vecs[i].btnl, vecs[i].btnd, vecs[i].ready, vecs[i].busy,
                vecs[i].words});
      end

      // run_led rises 5 cycles after sw[12], falls 200 cycles later.
      tick(5);
      run_led = 1'b1;
      tick(145);
      check("running_mid", {sw, busy, halted, error}, {13'h1080, 1'b1, 1'b0, 1'b0});
      tick(55);
      run_led = 1'b0;
      tick(1);
      check("halt_edge", {halted, sw, busy}, {1'b1, 13'h0080, 1'b0});
      tick(1);
      check("halt_after", {halted, sw, busy}, {1'b0, 13'h0080, 1'b0});
      check("halt_pulse_count", 64'(halted_cnt), 64'd1);

      // Reload from HALTED: three words with 50-cycle valid gaps.
      pulse_start();
      check("reload_enter", {word_ready, busy, error, words_loaded},
            {1'b1, 1'b1, 1'b0, 13'd0});
      ab = addr_log.size();
      db = data_log.size();
      exp_addr = '{12'o0100, 12'o0101, 12'o7777, 12'o0200};
      exp_data = '{12'o1234, 12'o0000, 12'o5555};
      for (int i = 0; i < 3; i++) begin
         tick(50);
         if (i == 1) begin
            pulse_start();
            check("start_while_busy", {busy, word_ready, words_loaded},
                  {1'b1, 1'b0, 13'd0});
         end
         send_word(exp_addr[i], exp_data[i], i == 2);
      end
      n = 0;
      while (sw[12] !== 1'b1 && n < 400) begin
         tick(1);
         n++;
      end
      check("run_switch_wait", 64'(n < 400), 64'd1);
      t_run = cyc;
      check("stream_words", 64'(words_loaded), 64'd3);
      check("addr_press_count", 64'(addr_log.size() - ab), 64'd4);
      check("data_press_count", 64'(data_log.size() - db), 64'd3);
      for (int i = 0; i < 4; i++)
         if (ab + i < addr_log.size())
            check($sformatf("addr_press%0d", i), 64'(addr_log[ab + i]), 64'(exp_addr[i]));
      for (int i = 0; i < 3; i++)
         if (db + i < data_log.size())
            check($sformatf("data_press%0d", i), 64'(data_log[db + i]), 64'(exp_data[i]));

      // run_led held low: error exactly RUN_TIMEOUT cycles after sw[12] rose.
      n = 0;
      while (error !== 1'b1 && n < 1100) begin
         tick(1);
         n++;
      end
      check("timeout_wait", 64'(n < 1100), 64'd1);
      check("timeout_latency", 64'(cyc - t_run), 64'd1024);
      check("timeout_state", {sw, busy, halted, error}, {13'h0080, 1'b0, 1'b0, 1'b1});
      check("timeout_no_halt_pulse", 64'(halted_cnt), 64'd1);

      // Reset while the deposit button is held.
      pulse_start();
      check("restart_clears", {error, words_loaded, word_ready}, {1'b0, 13'd0, 1'b1});
      send_word(12'o0300, 12'o4321, 1'b0);
      n = 0;
      while (btnd !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      check("btnd_wait", 64'(n < 200), 64'd1);
      reset = 1'b1;
      tick(1);
      check("reset_mid_press", {obs(), error, halted}, '0);
      reset = 1'b0;
      tick(3);
      check("idle_after_reset", {busy, word_ready}, 2'b00);
      pulse_start();
      check("start_after_reset", {busy, word_ready}, 2'b11);
      send_word(12'o0400, 12'o1111, 1'b0);
      tick(99);
      check("nonlast_off99", {words_loaded, word_ready}, {13'd0, 1'b0});
      tick(1);
      check("nonlast_back_to_wait", {words_loaded, word_ready, busy, sw},
            {13'd1, 1'b1, 1'b1, 1'b0, 12'o1111});

      check("invariants", 64'(mon_viol), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
